// File: rtl/vga_func_pkg.sv
`default_nettype none
// ============================================================================
// vga_func_pkg : display function codes and sequencer state encoding
// Revision     : 1.0
// ============================================================================
package vga_func_pkg;

    localparam int FUNC_W = 2;

    localparam logic [FUNC_W-1:0] FUNC_VRAM     = 2'd0;
    localparam logic [FUNC_W-1:0] FUNC_GPU      = 2'd1;
    localparam logic [FUNC_W-1:0] FUNC_VRAM_ALT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_SWITCH     = 3'd3,
        ST_SETTLE     = 3'd4
    } seq_state_t;

    // Round-robin successor; anything at or past the last legal code wraps to 0.
    function automatic logic [FUNC_W-1:0] next_func(input logic [FUNC_W-1:0] cur,
                                                   input logic [FUNC_W-1:0] last);
        return (cur >= last) ? '0 : cur + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// button_debouncer : 2-flop synchronizer plus stability filter, emitting a
//                    one-cycle pulse per accepted low-to-high transition
// Revision         : 1.0
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int               HOLD     = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int               CNT_W    = (HOLD < 2) ? 1 : $clog2(HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    // Any cycle agreeing with the accepted level restarts the hold count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/function_sequencer.sv
`default_nettype none
// ============================================================================
// function_sequencer : safely switches the active display function, draining
//                      the GPU and blanking across a frame-aligned switch
// Revision           : 1.0
// ============================================================================
module function_sequencer
    import vga_func_pkg::*;
#(
    parameter int NUM_FUNCS       = 3,
    parameter int RESET_FUNC      = 0,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DRAIN_TIMEOUT   = 65535,
    parameter int SETTLE_FRAMES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       sel_valid,
    input  logic [1:0] sel_func,
    output logic       sel_ready,
    input  logic       frame_start,
    input  logic       gpu_busy,
    output logic       gpu_halt,
    output logic [1:0] current_function,
    output logic       force_blank,
    output logic       switch_busy
);

    localparam logic [FUNC_W:0]   NUM_FUNCS_C = NUM_FUNCS[FUNC_W:0];
    localparam logic [FUNC_W-1:0] LAST_FUNC   = FUNC_W'(NUM_FUNCS - 1);
    localparam logic [FUNC_W-1:0] RESET_CODE  = RESET_FUNC[FUNC_W-1:0];

    localparam int CNT_MAX = (DRAIN_TIMEOUT > SETTLE_FRAMES) ? DRAIN_TIMEOUT : SETTLE_FRAMES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);
    localparam bit               SETTLE_NONE = (SETTLE_FRAMES == 0);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [FUNC_W-1:0] target_q;
    logic [FUNC_W-1:0] target_d;
    logic [FUNC_W-1:0] func_q;
    logic [FUNC_W-1:0] func_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              halt_q;
    logic              halt_d;
    logic              blank_q;
    logic              blank_d;
    logic              busy_q;
    logic              busy_d;

    logic              btn_pulse;
    logic              host_legal;
    logic [FUNC_W-1:0] btn_target;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_next),
        .pulse_o (btn_pulse)
    );

    assign host_legal = ({1'b0, sel_func} < NUM_FUNCS_C);
    assign btn_target = next_func(func_q, LAST_FUNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= RESET_CODE;
            func_q   <= RESET_CODE;
            cnt_q    <= '0;
            halt_q   <= 1'b0;
            blank_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            func_q   <= func_d;
            cnt_q    <= cnt_d;
            halt_q   <= halt_d;
            blank_q  <= blank_d;
            busy_q   <= busy_d;
        end
    end

    // A host request, even an illegal one, shadows a coincident button pulse.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        func_d   = func_q;
        cnt_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (host_legal && (sel_func != func_q)) begin
                        target_d = sel_func;
                        state_d  = (func_q == FUNC_GPU) ? ST_DRAIN : ST_WAIT_FRAME;
                    end
                end else if (btn_pulse && (btn_target != func_q)) begin
                    target_d = btn_target;
                    state_d  = (func_q == FUNC_GPU) ? ST_DRAIN : ST_WAIT_FRAME;
                end
            end
            ST_DRAIN: begin
                if (!gpu_busy || (cnt_q == DRAIN_LAST)) begin
                    state_d = ST_WAIT_FRAME;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                func_d  = target_q;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (SETTLE_NONE) begin
                    state_d = ST_IDLE;
                end else if (frame_start) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        halt_d  = (state_d == ST_DRAIN) || (state_d == ST_WAIT_FRAME) || (state_d == ST_SWITCH);
        blank_d = (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
        busy_d  = (state_d != ST_IDLE);
    end

    assign sel_ready        = (state_q == ST_IDLE);
    assign gpu_halt         = halt_q;
    assign force_blank      = blank_q;
    assign switch_busy      = busy_q;
    assign current_function = func_q;

endmodule
`default_nettype wire

// File: tb/tb_function_sequencer.sv
`default_nettype none
// tb_function_sequencer: directed scenarios and random traffic, checked every cycle
// against a behavioural model of the switching rules plus literal expectations.
module tb_function_sequencer;

    localparam int NF = 3;
    localparam int RF = 0;
    localparam int DB = 8;
    localparam int DT = 150;
    localparam int SF = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       sel_valid;
    logic [1:0] sel_func;
    logic       frame_start;
    logic       gpu_busy;
    logic       sel_ready;
    logic       gpu_halt;
    logic       force_blank;
    logic       switch_busy;
    logic [1:0] current_function;

    int checks = 0;
    int errors = 0;

    function_sequencer #(
        .NUM_FUNCS       (NF),
        .RESET_FUNC      (RF),
        .DEBOUNCE_CYCLES (DB),
        .DRAIN_TIMEOUT   (DT),
        .SETTLE_FRAMES   (SF)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_next         (btn_next),
        .sel_valid        (sel_valid),
        .sel_func         (sel_func),
        .sel_ready        (sel_ready),
        .frame_start      (frame_start),
        .gpu_busy         (gpu_busy),
        .gpu_halt         (gpu_halt),
        .current_function (current_function),
        .force_blank      (force_blank),
        .switch_busy      (switch_busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endfunction

    // Model: phase 0 idle, 1 draining, 2 awaiting frame, 3 switching, 4 settling.
    int m_phase, m_cur, m_tgt, m_spent, m_frames;
    bit m_stable, m_pend;
    bit bq[$];   // raw button level seen at each of the last DB+2 clock edges

    function automatic void model_reset();
        m_phase = 0; m_cur = RF; m_tgt = RF; m_spent = 0; m_frames = 0;
        m_stable = 1'b0; m_pend = 1'b0;
        bq.delete();
        for (int i = 0; i < DB + 2; i++) bq.push_back(1'b0);
    endfunction

    function automatic void model_step();
        bit pulse, flip;
        int req;
        pulse = m_pend;
        bq.push_back(btn_next);
        if (bq.size() > DB + 2) void'(bq.pop_front());
        // Accepted level flips once DB consecutive synchronized samples disagree with it.
        flip = 1'b1;
        for (int i = 0; i < DB; i++) if (bq[i] == m_stable) flip = 1'b0;
        m_pend = 1'b0;
        if (flip) begin
            m_stable = !m_stable;
            m_pend   = m_stable;
        end
        case (m_phase)
            0: begin
                req = -1;
                if (sel_valid) begin
                    if (int'(sel_func) < NF) req = int'(sel_func);
                end else if (pulse) begin
                    req = (m_cur + 1) % NF;
                end
                if (req >= 0 && req != m_cur) begin
                    m_tgt = req; m_spent = 0;
                    m_phase = (m_cur == 1) ? 1 : 2;
                end
            end
            1: begin
                m_spent++;
                if (!gpu_busy || m_spent >= DT) m_phase = 2;
            end
            2: if (frame_start) m_phase = 3;
            3: begin m_cur = m_tgt; m_phase = 4; m_frames = 0; end
            4: begin
                if (SF == 0) m_phase = 0;
                else if (frame_start) begin
                    m_frames++;
                    if (m_frames == SF) m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        check("sel_ready",        sel_ready,        16'(m_phase == 0));
        check("gpu_halt",         gpu_halt,         16'(m_phase >= 1 && m_phase <= 3));
        check("force_blank",      force_blank,      16'(m_phase >= 3));
        check("switch_busy",      switch_busy,      16'(m_phase != 0));
        check("current_function", current_function, 16'(m_cur));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (switch_busy && n < 1000) begin
            frame_start = (n % 5 == 0);
            tick();
            n++;
        end
        frame_start = 1'b0;
        check(tag, switch_busy, 16'd0);
    endtask

    task automatic switch_to(input logic [1:0] f);
        sel_valid = 1'b1; sel_func = f; tick(); sel_valid = 1'b0;
        wait_idle("switch_to_idle");
    endtask

    task automatic press_button();
        btn_next = 1'b1; repeat (20) tick(); btn_next = 1'b0;
        wait_idle("button_idle");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cur"},   current_function, 16'(RF));
        check({tag, "_halt"},  gpu_halt,    16'd0);
        check({tag, "_blank"}, force_blank, 16'd0);
        check({tag, "_busy"},  switch_busy, 16'd0);
        check({tag, "_ready"}, sel_ready,   16'd1);
    endtask

    initial begin
        int n;
        int hold;
        rst = 1'b1; btn_next = 1'b0; sel_valid = 1'b0; sel_func = 2'd0;
        frame_start = 1'b0; gpu_busy = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Host select 0 -> 2: straight to frame wait, switch after frame, two settle frames.
        sel_valid = 1'b1; sel_func = 2'd2; tick(); sel_valid = 1'b0;
        check("h2_busy", switch_busy, 16'd1);
        check("h2_halt", gpu_halt, 16'd1);
        check("h2_blank", force_blank, 16'd0);
        repeat (5) tick();
        check("h2_wait_cur", current_function, 16'd0);
        pulse_frame();
        check("h2_switch_blank", force_blank, 16'd1);
        check("h2_switch_cur", current_function, 16'd0);
        tick();
        check("h2_cur", current_function, 16'd2);
        pulse_frame();
        check("h2_settle_busy", switch_busy, 16'd1);
        repeat (3) tick();
        pulse_frame();
        check("h2_idle", switch_busy, 16'd0);
        check("h2_idle_blank", force_blank, 16'd0);

        // Leaving function 1 while the GPU is busy: frames during drain are ignored.
        switch_to(2'd1);
        check("to1_cur", current_function, 16'd1);
        gpu_busy = 1'b1;
        sel_valid = 1'b1; sel_func = 2'd0; tick(); sel_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            frame_start = (i % 10 == 0);
            tick();
        end
        frame_start = 1'b0;
        check("drain_halt", gpu_halt, 16'd1);
        check("drain_blank", force_blank, 16'd0);
        check("drain_cur", current_function, 16'd1);
        gpu_busy = 1'b0;
        repeat (4) tick();
        check("drained_blank", force_blank, 16'd0);
        pulse_frame();
        check("drained_switch", force_blank, 16'd1);
        wait_idle("drain_idle");
        check("drain_final_cur", current_function, 16'd0);

        // GPU stuck busy with frame_start held: DT drain cycles plus one wait cycle.
        switch_to(2'd1);
        gpu_busy = 1'b1; frame_start = 1'b1;
        sel_valid = 1'b1; sel_func = 2'd0; tick(); sel_valid = 1'b0;
        n = 0;
        while (switch_busy && !force_blank && n < 400) begin
            n++;
            tick();
        end
        check("timeout_len", 16'(n), 16'(DT + 1));
        frame_start = 1'b0; gpu_busy = 1'b0;
        wait_idle("timeout_idle");
        check("timeout_cur", current_function, 16'd0);

        // Bouncing button then a stable press: one advance; from 2 it wraps to 0.
        for (int i = 0; i < 10; i++) begin
            btn_next = 1'b1; repeat (3) tick();
            btn_next = 1'b0; repeat (2) tick();
        end
        check("bounce_no_switch", switch_busy, 16'd0);
        press_button();
        check("button_adv", current_function, 16'd1);
        switch_to(2'd2);
        press_button();
        check("button_wrap", current_function, 16'd0);
        repeat (20) tick();

        // Illegal code, same-code request, and host request coinciding with a button pulse.
        sel_valid = 1'b1; sel_func = 2'd3; tick(); sel_valid = 1'b0;
        check("illegal_busy", switch_busy, 16'd0);
        check("illegal_cur", current_function, 16'd0);
        sel_valid = 1'b1; sel_func = 2'd0; tick(); sel_valid = 1'b0;
        check("same_busy", switch_busy, 16'd0);
        btn_next = 1'b1;
        repeat (DB + 1) tick();
        sel_valid = 1'b1; sel_func = 2'd2; tick(); sel_valid = 1'b0;
        check("collide_busy", switch_busy, 16'd1);
        repeat (10) tick();
        btn_next = 1'b0;
        wait_idle("collide_idle");
        check("collide_cur", current_function, 16'd2);
        repeat (20) tick();

        // Reset while waiting for a frame: the pending target must be forgotten.
        sel_valid = 1'b1; sel_func = 2'd1; tick(); sel_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_wait");
        tick(); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            frame_start = (i % 4 == 0);
            tick();
        end
        frame_start = 1'b0;
        check("rst_wait_after_busy", switch_busy, 16'd0);
        check("rst_wait_after_cur", current_function, 16'(RF));

        // Reset while settling after a completed switch.
        sel_valid = 1'b1; sel_func = 2'd2; tick(); sel_valid = 1'b0;
        pulse_frame();
        tick();
        check("pre_rst_settle_cur", current_function, 16'd2);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_settle");
        tick(); rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            frame_start = (i % 4 == 0);
            tick();
        end
        frame_start = 1'b0;
        check("rst_settle_after_busy", switch_busy, 16'd0);
        check("rst_settle_after_cur", current_function, 16'(RF));

        // Random traffic with occasional asynchronous resets.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            sel_valid   = ($urandom_range(0, 15) == 0);
            sel_func    = 2'($urandom_range(0, 3));
            frame_start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) gpu_busy = ~gpu_busy;
            if (hold == 0) begin
                btn_next = 1'($urandom_range(0, 1));
                hold     = $urandom_range(1, 20);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        sel_valid = 1'b0; frame_start = 1'b0; gpu_busy = 1'b0; btn_next = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
